// File: rtl/hist_tx_pkg.sv
// Shared types and constants for the histogram byte-stream transmitter.
package hist_tx_pkg;

    typedef enum logic [1:0] {IDLE, HEADER, DATA, CHECK} tx_state_t;

    localparam int         HIST_W_DEFAULT = 128;
    localparam int         HIST_BYTES     = HIST_W_DEFAULT / 8;
    localparam logic [7:0] HDR_DEFAULT    = 8'hA5;

endpackage

// File: rtl/byte_select.sv
// Combinational byte mux: picks byte[idx] (bits 8*idx+7 : 8*idx) out of a wide word.
module byte_select #(
    parameter int HIST_W = 128,
    parameter int IDX_W  = 4
) (
    input  logic [HIST_W-1:0] word,
    input  logic [IDX_W-1:0]  idx,
    output logic [7:0]        byte_out
);

    assign byte_out = word[{idx, 3'b000} +: 8];

endmodule

// File: rtl/hist_stream_tx.sv
// Snapshots the histogram on start and sends it as header, data bytes (bin 0 first), XOR checksum.
//   state  | meaning
//   IDLE   | waiting for start, outputs quiet
//   HEADER | presenting the frame header byte
//   DATA   | presenting snapshot byte[idx], folding accepted bytes into the checksum
//   CHECK  | presenting the checksum with out_last set
module hist_stream_tx #(
    parameter int         HIST_W = hist_tx_pkg::HIST_W_DEFAULT,
    parameter logic [7:0] HDR    = hist_tx_pkg::HDR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [HIST_W-1:0] hist_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done
);
    import hist_tx_pkg::*;

    localparam int               N_BYTES  = HIST_W / 8;
    localparam int               IDX_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BYTES - 1);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [HIST_W-1:0] snap;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        chk;
    logic [7:0]        data_byte;

    byte_select #(
        .HIST_W (HIST_W),
        .IDX_W  (IDX_W)
    ) u_byte_select (
        .word     (snap),
        .idx      (idx),
        .byte_out (data_byte)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            snap       <= '0;
            idx        <= '0;
            chk        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= (state == CHECK) && out_ready;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap <= hist_in;
                        idx  <= '0;
                        chk  <= '0;
                    end
                end
                DATA: begin
                    if (out_ready) begin
                        chk <= chk ^ data_byte;
                        // idx holds at the last byte so it never wraps inside a frame
                        if (idx != IDX_LAST) begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)                        state_nxt = HEADER;
            HEADER:  if (out_ready)                    state_nxt = DATA;
            DATA:    if (out_ready && idx == IDX_LAST) state_nxt = CHECK;
            CHECK:   if (out_ready)                    state_nxt = IDLE;
            default:                                   state_nxt = IDLE;
        endcase
    end

    // Outputs decode from registered state only, so out_valid never depends on out_ready.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: ;
            HEADER: begin
                out_valid = 1'b1;
                out_data  = HDR;
                busy      = 1'b1;
            end
            DATA: begin
                out_valid = 1'b1;
                out_data  = data_byte;
                busy      = 1'b1;
            end
            CHECK: begin
                out_valid = 1'b1;
                out_data  = chk;
                out_last  = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hist_stream_tx.sv
// Directed bench for hist_stream_tx: framing, checksum, backpressure, snapshot, reset and back-to-back.
module tb_hist_stream_tx;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [127:0] hist_in = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         out_last;
    logic         busy;
    logic         frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int stall_err = 0;
    int done_seen = 0;
    int edges = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    localparam logic [127:0] PAT_BASIC = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] PAT_CHK   = 128'h0000_0000_0000_0000_0000_0000_0000_3412;
    localparam logic [127:0] PAT_RST   = 128'h0000_0000_0000_0000_0000_0000_0000_005A;
    localparam int LIMIT = 400;

    hist_stream_tx dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .hist_in    (hist_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void build_exp(input logic [127:0] h);
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(h[8*k +: 8]);
            x ^= h[8*k +: 8];
        end
        exp_q.push_back(x);
    endfunction

    task automatic compare_frame(input string tag);
        check_eq({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
            check_eq($sformatf("%s_b%0d", tag, k), rx_q[k], exp_q[k]);
    endtask

    // Called just after a clock edge while idle; start is sampled on the next edge.
    task automatic start_frame(input logic [127:0] h);
        hist_in = h;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        check_eq("start_hdr", {busy, out_valid, out_data, out_last}, {1'b1, 1'b1, 8'hA5, 1'b0});
    endtask

    // Drives out_ready and records accepted bytes until the last byte or max_acc bytes are accepted.
    task automatic collect(input int pct, input int max_acc, input int poke_at);
        int          cyc;
        logic        pv, pl, pr, got_last;
        logic [7:0]  pd;
        cyc = 0;
        got_last = 1'b0;
        rx_q.delete();
        done_seen = 0;
        while (!got_last && rx_q.size() < max_acc && cyc < LIMIT) begin
            out_ready = ($urandom_range(0, 99) < pct);
            if (cyc == poke_at) begin
                hist_in = '1;
                start   = 1'b1;
            end else if (cyc == poke_at + 1) begin
                start   = 1'b0;
            end
            pv = out_valid; pd = out_data; pl = out_last; pr = out_ready;
            @(posedge clk); #1;
            cyc++;
            if (frame_done) done_seen++;
            if (pv && pr) begin
                rx_q.push_back(pd);
                if (pl) got_last = 1'b1;
            end else if (pv && !pr) begin
                if ({out_valid, out_data, out_last} !== {pv, pd, pl}) stall_err++;
            end
        end
        start = 1'b0;
        edges = cyc;
        check_eq("within_budget", cyc < LIMIT, 1'b1);
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("rst_outs", {out_valid, out_data, out_last, busy, frame_done}, 12'h000);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_outs", {out_valid, out_data, out_last, busy, frame_done}, 12'h000);

        // Basic frame
        build_exp(PAT_BASIC);
        start_frame(PAT_BASIC);
        collect(100, 18, -10);
        compare_frame("basic");
        check_eq("basic_hdr", rx_q[0], 8'hA5);
        check_eq("basic_b16", rx_q[16], 8'h0F);
        check_eq("basic_csum", rx_q[17], 8'h00);
        check_eq("basic_edges", edges, 18);
        check_eq("basic_done", {frame_done, busy, out_valid}, 3'b100);
        check_eq("basic_done_cnt", done_seen, 1);
        @(posedge clk); #1;
        check_eq("done_pulse_width", frame_done, 1'b0);

        // Checksum
        build_exp(PAT_CHK);
        start_frame(PAT_CHK);
        collect(100, 18, -10);
        compare_frame("csum");
        check_eq("csum_val", rx_q[17], 8'h26);
        @(posedge clk); #1;

        // Backpressure
        build_exp(PAT_BASIC);
        stall_err = 0;
        start_frame(PAT_BASIC);
        collect(40, 18, -10);
        compare_frame("bp");
        check_eq("bp_stall_stable", stall_err, 0);
        check_eq("bp_done_cnt", done_seen, 1);
        @(posedge clk); #1;

        // Snapshot and ignored start
        build_exp(PAT_BASIC);
        start_frame(PAT_BASIC);
        collect(100, 18, 5);
        compare_frame("snap");
        check_eq("snap_done_cnt", done_seen, 1);
        begin
            int extra_done = 0;
            int extra_busy = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (frame_done) extra_done++;
                if (busy) extra_busy++;
            end
            check_eq("snap_no_more_done", extra_done, 0);
            check_eq("snap_no_second_frame", extra_busy, 0);
        end

        // Reset mid-frame at idx 7 of DATA
        start_frame(PAT_BASIC);
        collect(100, 8, -10);
        check_eq("rst_pre_accepts", rx_q.size(), 8);
        check_eq("rst_pre_data", {busy, out_data}, {1'b1, 8'h07});
        #3;
        reset = 1'b0;
        #1;
        check_eq("rst_async_outs", {out_valid, out_data, out_last, busy, frame_done}, 12'h000);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;
        build_exp(PAT_RST);
        start_frame(PAT_RST);
        collect(100, 18, -10);
        compare_frame("rst_new");
        check_eq("rst_new_csum", rx_q[17], 8'h5A);
        @(posedge clk); #1;

        // Back-to-back with start held high
        build_exp(PAT_CHK);
        hist_in = PAT_CHK;
        start   = 1'b1;
        @(posedge clk); #1;
        check_eq("b2b_first_hdr", {busy, out_data}, {1'b1, 8'hA5});
        out_ready = 1'b1;
        begin
            int idle_cycles = 0;
            int guard = 0;
            while (!frame_done && guard < 40) begin
                @(posedge clk); #1;
                guard++;
            end
            check_eq("b2b_done_seen", frame_done, 1'b1);
            check_eq("b2b_idle_cycle", {frame_done, busy, out_valid}, 3'b100);
            if (!busy) idle_cycles++;
            @(posedge clk); #1;
            if (!busy) idle_cycles++;
            check_eq("b2b_idle_count", idle_cycles, 1);
            check_eq("b2b_second_hdr", {busy, out_valid, out_data, frame_done}, {2'b11, 8'hA5, 1'b0});
        end
        start = 1'b0;
        collect(100, 18, -10);
        rx_q.push_front(8'hA5);
        rx_q.pop_back();
        // header was already on the bus when collect began; realign to a full frame
        rx_q.delete();
        build_exp(PAT_CHK);
        begin
            logic [7:0] b;
            int         guard;
            guard = 0;
            start_frame(PAT_CHK);
            collect(100, 18, -10);
            compare_frame("b2b_tail");
            guard++;
            b = rx_q[17];
            check_eq("b2b_tail_csum", b, 8'h26);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
